// File: rtl/vc_ram_bank.sv
// vc_ram_bank
//   Simple dual-port RAM (one write port, one read port) split into NUM_VC
//   independent banks of 2**ADDR_WIDTH words each. Storage only; the VC FIFO
//   controllers above this block own all pointers.
//
//   Features: bank select, same-cycle write-to-read bypass, optional output
//   register (read latency 1 or 2), read-valid strobe, and a sequential clear
//   sweep (one address per cycle across all banks) instead of an array reset.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   clear    in   one-cycle pulse, zero every bank (ignored while busy)
//   busy     out  clear sweep in progress, port operations ignored
//   wr_en    in   write strobe
//   wr_vc    in   write bank select (out-of-range banks drop the write)
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read strobe
//   rd_vc    in   read bank select (out-of-range banks read as zero)
//   rd_addr  in   read address
//   rd_data  out  read data, zero whenever rd_valid is low
//   rd_valid out  rd_data carries the result of an accepted read
module vc_ram_bank #(
    parameter  int DATA_WIDTH     = 32,
    parameter  int ADDR_WIDTH     = 3,
    parameter  int NUM_VC         = 2,
    parameter  int OUT_REG        = 0,
    parameter  int CLEAR_ON_RESET = 1,
    localparam int VCW            = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    output logic                  busy,
    input  logic                  wr_en,
    input  logic [VCW-1:0]        wr_vc,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [VCW-1:0]        rd_vc,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    // The array is indexed by {vc, addr}, so it is sized to the full index
    // space; entries belonging to non-existent banks are never written.
    localparam int                  MEM_WORDS = 1 << (VCW + ADDR_WIDTH);
    localparam logic [VCW:0]        VC_LIMIT  = (VCW + 1)'(NUM_VC);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q;
    logic                    busy_q;
    logic [DATA_WIDTH-1:0]   mem_q [MEM_WORDS];

    logic                    s1_valid_q;
    logic [DATA_WIDTH-1:0]   s1_data_q;
    logic                    s2_valid_q;
    logic [DATA_WIDTH-1:0]   s2_data_q;

    logic                    wr_ok_d;
    logic                    rd_ok_d;
    logic                    rd_vc_ok_d;
    logic                    bypass_d;
    logic [DATA_WIDTH-1:0]   rd_word_d;

    // Port acceptance, bypass detection and the read word for stage 1.
    always_comb begin
        wr_ok_d    = wr_en & ~busy_q & ~clear & ~rst & ({1'b0, wr_vc} < VC_LIMIT);
        rd_ok_d    = rd_en & ~busy_q & ~clear;
        rd_vc_ok_d = ({1'b0, rd_vc} < VC_LIMIT);
        bypass_d   = wr_ok_d & (wr_vc == rd_vc) & (wr_addr == rd_addr);
        rd_word_d  = '0;
        if (!rd_ok_d || !rd_vc_ok_d) begin
            // Idle cycles and reads of a non-existent bank both yield zero.
            rd_word_d = '0;
        end else if (bypass_d) begin
            rd_word_d = wr_data;
        end else begin
            rd_word_d = mem_q[{rd_vc, rd_addr}];
        end
    end

    // Clear sweep controller: IDLE <-> CLEAR, one address per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clr_cnt_q <= '0;
            busy_q    <= (CLEAR_ON_RESET != 0);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clear) begin
                        state_q   <= ST_CLEAR;
                        clr_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    // clear pulses are ignored here so the sweep never restarts
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    clr_cnt_q <= '0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    // Storage: sweep writes zero to clr_cnt in every bank, else the write port.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            for (int v = 0; v < NUM_VC; v++) begin
                mem_q[{VCW'(v), clr_cnt_q}] <= '0;
            end
        end else if (wr_ok_d) begin
            mem_q[{wr_vc, wr_addr}] <= wr_data;
        end
    end

    // Read pipeline: stage 1 always loads (zero when idle), stage 2 follows it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= rd_ok_d;
            s1_data_q  <= rd_word_d;
            s2_valid_q <= s1_valid_q;
            s2_data_q  <= s1_data_q;
        end
    end

    assign busy     = busy_q;
    assign rd_valid = (OUT_REG != 0) ? s2_valid_q : s1_valid_q;
    assign rd_data  = (OUT_REG != 0) ? s2_data_q  : s1_data_q;

endmodule

// File: doc/vc_ram_bank.md
# vc_ram_bank

Parametrised single-clock simple dual-port RAM: one write port, one read port, NUM_VC independent banks of 2**ADDR_WIDTH words each. It generalises the fixed 8x32 router buffer RAM with bank (virtual-channel) select, write-to-read bypass, an optional output register, a read-valid strobe, and a sequential clear engine in place of a whole-array reset. It sits under the per-port VC FIFO controllers in the mesh router; the controllers own pointers, and this block owns storage only.

## Interface
- DATA_WIDTH, 32, word width in bits
- ADDR_WIDTH, 3, address bits per bank; DEPTH = 2**ADDR_WIDTH
- NUM_VC, 2, number of banks (>=1); VCW = max(1, clog2(NUM_VC))
- OUT_REG, 0, 0: read latency 1; 1: extra output register, latency 2
- CLEAR_ON_RESET, 1, 1: run a clear sweep after reset; 0: contents undefined after reset

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- clear  in  1  one-cycle pulse: zero all banks
- busy  out  1  clear sweep in progress; port operations ignored
- wr_en  in  1  write strobe
- wr_vc  in  VCW  write bank select
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- rd_en  in  1  read strobe
- rd_vc  in  VCW  read bank select
- rd_addr  in  ADDR_WIDTH  read address
- rd_data  out  DATA_WIDTH  read data; zero when rd_valid is low
- rd_valid  out  1  rd_data holds the result of an accepted read

## Operation
- Clear FSM, two states: IDLE, CLEAR; counter clr_cnt of ADDR_WIDTH bits.
- rst high at an edge: state <= CLEAR if CLEAR_ON_RESET else IDLE; clr_cnt <= 0; busy <= CLEAR_ON_RESET; all read pipeline stages <= 0 (rd_data 0, rd_valid 0).
- CLEAR: each edge writes 0 to address clr_cnt in every bank; clr_cnt increments; at clr_cnt == DEPTH-1 the state goes to IDLE and busy goes to 0 on that edge.
- IDLE + clear=1: state <= CLEAR, clr_cnt <= 0, busy <= 1. Any wr_en/rd_en in that cycle is ignored.
- clear while busy: ignored; the sweep continues without restarting.
- rst during a sweep: the sweep restarts from address 0 (CLEAR_ON_RESET=1) or aborts (=0).
- Write accepted when wr_en & !busy & !clear & wr_vc < NUM_VC; otherwise dropped silently, with no storage change.
- Read accepted when rd_en & !busy & !clear. If rd_vc >= NUM_VC, the read is still accepted and returns 0 with rd_valid=1.
- Bypass: an accepted read and an accepted write in the same cycle with equal vc and addr return the new wr_data, not the old contents.
- Non-accepted cycle: the first read stage loads rd_data=0, rd_valid=0, matching the existing buffer RAM's zero-when-idle output.
- Reads already in the pipeline when clear is pulsed complete normally, with pre-clear data.
- Different banks, or different addresses in one bank, are fully independent in the same cycle.

## Timing
- OUT_REG=0: a read accepted at edge N gives rd_data/rd_valid valid after edge N, for exactly one cycle.
- OUT_REG=1: valid after edge N+1. Back-to-back reads give one result per cycle, with no bubbles.
- Write at edge N is visible to a read accepted at edge N+1 or later, and at edge N via bypass.
- After rst is released: busy=1 for DEPTH cycles when CLEAR_ON_RESET=1. The first accepted operation is at the first edge where busy=0.
- clear pulse at edge N: busy=1 from after edge N until after edge N+DEPTH, which is DEPTH cycles high.
- No combinational path from inputs to outputs.

## Test plan
- Reset sweep (defaults): release rst, count busy-high cycles -> exactly 8. Read all 16 (vc, addr) pairs -> all 0, rd_valid=1 one cycle after each rd_en.
- Write then read: write 0xDEADBEEF to vc1/addr5 and 0x12345678 to vc0/addr5. Read vc1/addr5 -> 0xDEADBEEF; vc0/addr5 -> 0x12345678. With rd_en low, rd_data=0 and rd_valid=0.
- Bypass: vc0/addr2 holds 0x11. Write 0x22 and read vc0/addr2 in the same cycle -> 0x22. Same cycle with read vc1/addr2 -> the old vc1 value.
- Clear mid-traffic: fill all words with 0xA5A5A5A5 and pulse clear. wr_en during busy (vc0/addr0, 0xFF) -> dropped. After busy falls, all reads -> 0. A second clear pulse during busy does not extend busy beyond 8 cycles.
- OUT_REG=1, NUM_VC=3: 4 back-to-back reads -> results arrive 2 cycles after each rd_en, 4 consecutive valid cycles. Write to vc3 -> ignored. Read vc3 -> 0 with rd_valid=1.
- Reset mid-sweep: assert rst at sweep cycle 4 -> busy stays high, and a full 8-cycle sweep follows release. The read pipeline outputs 0 during rst.
